pipe_stage_ctrl: RTL and testbench

- Central sequencer for the 5-stage RV32I pipeline.
- Inputs: hazard requests (load-use stall, IF/ID flush, EX flush) and memory ready handshakes.
- Outputs: per-pipeline-register enables, PC enable and per-stage valid bits.
- Sits between the hazard detection logic and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A data-memory wait watchdog flags hung accesses.

---
 rtl/pipe_stage_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: central sequencer for the 5-stage RV32I pipeline.
//
// It turns hazard requests and memory handshakes into per-pipeline-register
// enables, a PC enable and per-stage valid bits. A watchdog flags a data
// access that keeps the pipeline frozen for too long.
//
// Optional feature: define PIPE_PERF_CNT_EN to add the stall and flush
// performance counters (ports perf_stall_cnt / perf_flush_cnt).
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   stall_req         : load-use hazard (hold IF/ID, bubble into EX)
//   if_id_flush_req   : kill IF/ID contents
//   ex_flush_req      : kill IF/ID and ID/EX contents
//   imem_ready        : fetch data valid this cycle
//   mem_access        : instruction in MEM is a load/store
//   dmem_ready        : data memory completes the access this cycle
//   pc_en, *_en       : PC and pipeline register load enables
//   *_valid           : stage holds a real instruction
//   retire            : valid instruction leaves WB this cycle
//   timeout_err       : sticky watchdog error
//   perf_*_cnt        : saturating counters (PIPE_PERF_CNT_EN only)
module pipe_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic stall_req,
  input  logic if_id_flush_req,
  input  logic ex_flush_req,
  input  logic imem_ready,
  input  logic mem_access,
  input  logic dmem_ready,
  output logic pc_en,
  output logic if_id_en,
  output logic id_ex_en,
  output logic ex_mem_en,
  output logic mem_wb_en,
  output logic id_valid,
  output logic ex_valid,
  output logic mem_valid,
  output logic wb_valid,
  output logic retire,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] perf_stall_cnt,
  output logic [CNT_WIDTH-1:0] perf_flush_cnt,
`endif
  output logic timeout_err
);

  typedef enum logic [1:0] {BOOT, RUN, DMEM_WAIT} state_e;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            id_q, ex_q, mem_q, wb_q;
  logic            id_d, ex_d, mem_d, wb_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            terr_q, terr_d;

  logic active, freeze, take_flush, take_stall;
  logic pc_en_c, if_id_en_c, rest_en_c;

  always_comb begin
    active     = (state_q != BOOT);
    // MEM holds an unfinished data access: nothing may move.
    freeze     = active & mem_q & mem_access & ~dmem_ready;
    take_flush = 1'b0;
    take_stall = 1'b0;
    pc_en_c    = 1'b0;
    if_id_en_c = 1'b0;
    rest_en_c  = 1'b0;
    id_d       = id_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;

    if (!active)     state_d = RUN;
    else if (freeze) state_d = DMEM_WAIT;
    else             state_d = RUN;

    if (active && !freeze) begin
      if_id_en_c = 1'b1;
      rest_en_c  = 1'b1;
      mem_d      = ex_q;
      wb_d       = mem_q;
      // Flushes outrank the stall: a stalled instruction behind a
      // redirect is on the wrong path anyway.
      if (ex_flush_req) begin
        take_flush = 1'b1;
        pc_en_c    = 1'b1;
        id_d       = 1'b0;
        ex_d       = 1'b0;
      end else if (if_id_flush_req) begin
        take_flush = 1'b1;
        pc_en_c    = 1'b1;
        id_d       = 1'b0;
        ex_d       = id_q;
      end else if (stall_req) begin
        take_stall = 1'b1;
        if_id_en_c = 1'b0;
        ex_d       = 1'b0;
      end else if (!imem_ready) begin
        id_d       = 1'b0;
        ex_d       = id_q;
      end else begin
        pc_en_c    = 1'b1;
        id_d       = 1'b1;
        ex_d       = id_q;
      end
    end

    // Watchdog counts consecutive frozen cycles (the cycles the pipeline
    // spends waiting on data memory); the error fires on the last one.
    if (freeze) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    else        wd_d = '0;
    terr_d = terr_q | (freeze & (wd_q == WD_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      id_q    <= 1'b0;
      ex_q    <= 1'b0;
      mem_q   <= 1'b0;
      wb_q    <= 1'b0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  assign pc_en       = pc_en_c;
  assign if_id_en    = if_id_en_c;
  assign id_ex_en    = rest_en_c;
  assign ex_mem_en   = rest_en_c;
  assign mem_wb_en   = rest_en_c;
  assign id_valid    = id_q;
  assign ex_valid    = ex_q;
  assign mem_valid   = mem_q;
  assign wb_valid    = wb_q;
  assign retire      = wb_q & active & ~freeze;
  assign timeout_err = terr_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (take_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (take_flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Testbench for pipe_stage_ctrl: a fixed vector table from reset, random
// stimulus against a reference model, and hand sequences for the data
// memory freeze, the watchdog and asynchronous reset during a freeze.
module tb_pipe_stage_ctrl;
  localparam int TO = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall_req = 0, if_id_flush_req = 0, ex_flush_req = 0;
  logic imem_ready = 0, mem_access = 0, dmem_ready = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic id_valid, ex_valid, mem_valid, wb_valid, retire, timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .stall_req(stall_req), .if_id_flush_req(if_id_flush_req),
    .ex_flush_req(ex_flush_req), .imem_ready(imem_ready),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .retire(retire),
`ifdef PIPE_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stage occupancy is kept as an array v[0..3] = {ID, EX, MEM, WB}.
  bit m_boot;
  bit v[4];
  int m_wait, m_stalls, m_flushes;
  bit m_terr;

  function automatic void model_reset();
    m_boot = 1; m_wait = 0; m_stalls = 0; m_flushes = 0; m_terr = 0;
    foreach (v[i]) v[i] = 0;
  endfunction

  function automatic bit m_frozen(input logic [5:0] s);
    return !m_boot && v[2] && s[1] && !s[0];
  endfunction

  // s = {stall, if_id_flush, ex_flush, imem_ready, mem_access, dmem_ready}
  task automatic drive(input logic [5:0] s);
    {stall_req, if_id_flush_req, ex_flush_req, imem_ready, mem_access, dmem_ready} = s;
  endtask

  task automatic model_step(input logic [5:0] s);
    bit o[4];
    o = v;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_frozen(s)) begin
      m_wait++;
      if (m_wait >= TO) m_terr = 1;
    end else begin
      m_wait = 0;
      v[3] = o[2];
      v[2] = o[1];
      if (s[3]) begin
        v[0] = 0; v[1] = 0;
        if (m_flushes < 2**CW - 1) m_flushes++;
      end else if (s[4]) begin
        v[0] = 0; v[1] = o[0];
        if (m_flushes < 2**CW - 1) m_flushes++;
      end else if (s[5]) begin
        v[1] = 0;
        if (m_stalls < 2**CW - 1) m_stalls++;
      end else begin
        v[1] = o[0];
        v[0] = s[2];
      end
    end
  endtask

  // One cycle: called at posedge+1, compares at posedge+4, ends at next posedge+1.
  task automatic cyc(input logic [5:0] s);
    bit fz, run, epc, eifid;
    drive(s);
    #3;
    fz  = m_frozen(s);
    run = !m_boot && !fz;
    epc   = run && (s[3] || s[4] || (!s[5] && s[2]));
    eifid = run && (s[3] || s[4] || !s[5]);
    chk("pc_en",     pc_en,     epc);
    chk("if_id_en",  if_id_en,  eifid);
    chk("id_ex_en",  id_ex_en,  run);
    chk("ex_mem_en", ex_mem_en, run);
    chk("mem_wb_en", mem_wb_en, run);
    chk("id_valid",  id_valid,  v[0]);
    chk("ex_valid",  ex_valid,  v[1]);
    chk("mem_valid", mem_valid, v[2]);
    chk("wb_valid",  wb_valid,  v[3]);
    chk("retire",    retire,    run && v[3]);
    chk("timeout_err", timeout_err, m_terr);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stalls);
    chk("perf_flush_cnt", perf_flush_cnt, m_flushes);
`endif
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    drive(6'b000100);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [5:0] in;   // stall, iff, exf, imem, macc, drdy
    logic [7:0] ex;   // pc, ifid, idex, idv, exv, memv, wbv, retire
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [7:0] e;
    tbl[0]  = {6'b000100, 8'b00000000};  // BOOT
    tbl[1]  = {6'b000100, 8'b11100000};
    tbl[2]  = {6'b000100, 8'b11110000};
    tbl[3]  = {6'b000100, 8'b11111000};
    tbl[4]  = {6'b000100, 8'b11111100};
    tbl[5]  = {6'b000100, 8'b11111111};  // steady state, retiring
    tbl[6]  = {6'b100100, 8'b00111111};  // stall
    tbl[7]  = {6'b000100, 8'b11110111};  // bubble in EX
    tbl[8]  = {6'b000100, 8'b11111011};
    tbl[9]  = {6'b000100, 8'b11111100};  // retire gap
    tbl[10] = {6'b101100, 8'b11111111};  // ex flush + stall: flush wins
    tbl[11] = {6'b000100, 8'b11100111};
    tbl[12] = {6'b000100, 8'b11110011};
    tbl[13] = {6'b010100, 8'b11111000};  // if/id flush
    tbl[14] = {6'b000000, 8'b01101100};  // imem not ready
    tbl[15] = {6'b000110, 8'b00000110};  // freeze
    tbl[16] = {6'b000110, 8'b00000110};  // freeze
    tbl[17] = {6'b000111, 8'b11100111};  // access completes
    tbl[18] = {6'b000110, 8'b11110011};  // mem_access without valid MEM

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].in);
      #3;
      e = tbl[i].ex;
      chk($sformatf("tbl%0d pc_en", i),     pc_en,     e[7]);
      chk($sformatf("tbl%0d if_id_en", i),  if_id_en,  e[6]);
      chk($sformatf("tbl%0d id_ex_en", i),  id_ex_en,  e[5]);
      chk($sformatf("tbl%0d ex_mem_en", i), ex_mem_en, e[5]);
      chk($sformatf("tbl%0d mem_wb_en", i), mem_wb_en, e[5]);
      chk($sformatf("tbl%0d valids", i), {id_valid, ex_valid, mem_valid, wb_valid}, e[4:1]);
      chk($sformatf("tbl%0d retire", i),    retire,    e[0]);
      chk($sformatf("tbl%0d timeout_err", i), timeout_err, 1'b0);
`ifdef PIPE_PERF_CNT_EN
      if (i == 11) begin
        chk("tbl perf_stall_cnt", perf_stall_cnt, 1);
        chk("tbl perf_flush_cnt", perf_flush_cnt, 1);
      end
`endif
      @(posedge clk);
      #1;
    end

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [5:0] s;
      s[5] = ($urandom_range(0, 99) < 20);
      s[4] = ($urandom_range(0, 99) < 10);
      s[3] = ($urandom_range(0, 99) < 8);
      s[2] = ($urandom_range(0, 99) < 80);
      s[1] = ($urandom_range(0, 99) < 50);
      s[0] = ($urandom_range(0, 99) < 65);
      cyc(s);
    end

    // ---------------- 5-cycle data wait, then resume ----------------
    do_reset();
    for (int n = 0; n < 6; n++) cyc(6'b000100);
    chk("pre-wait mem_valid", mem_valid, 1'b1);
    for (int n = 0; n < 5; n++) begin
      cyc(6'b000110);
      chk("wait pc_en", pc_en, 1'b0);
      chk("wait valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b1111);
    end
    drive(6'b000111);
    #3;
    chk("resume pc_en", pc_en, 1'b1);
    chk("resume retire", retire, 1'b1);
    chk("short wait timeout_err", timeout_err, 1'b0);
    @(posedge clk); model_step(6'b000111); #1;

    // ---------------- watchdog ----------------
    for (int n = 0; n < TO - 1; n++) cyc(6'b000110);
    chk("63 waits timeout_err", timeout_err, 1'b0);
    cyc(6'b000110);
    chk("64 waits timeout_err", timeout_err, 1'b1);
    cyc(6'b000111);
    cyc(6'b000100);
    chk("sticky timeout_err", timeout_err, 1'b1);

    // ---------------- reset during a freeze ----------------
    for (int n = 0; n < 3; n++) cyc(6'b000100);
    cyc(6'b000110);
    drive(6'b000110);
    #2;
    reset = 1;
    #1;
    chk("async rst pc_en", pc_en, 1'b0);
    chk("async rst enables", {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 4'b0000);
    chk("async rst valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b0000);
    chk("async rst retire", retire, 1'b0);
    chk("async rst timeout_err", timeout_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    for (int n = 0; n < 8; n++) cyc(6'b000100);
    // Watchdog restarted from zero: 63 waits must not trip it.
    for (int n = 0; n < TO - 1; n++) cyc(6'b000110);
    chk("restart timeout_err", timeout_err, 1'b0);
    cyc(6'b000111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
